// File: rtl/gpio_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_ctrl -- memory-mapped GPIO block with optional edge-detect interrupt.
//
// Purpose
//   Provides output, direction and synchronised input registers for up to 32
//   pads. When built with the GPIO_IRQ_EN macro defined, it also provides
//   per-pin rising/falling edge detection, a sticky write-1-to-clear status
//   register and a level interrupt. The default build leaves GPIO_IRQ_EN
//   undefined; the edge logic is then absent, and indices 3-5 read as zero.
//
// Register map (word index = address bits [4:2])
//   0 OUT      RW    pad output values
//   1 DIR      RW    pad output enables (1 = drive)
//   2 IN       RO    pad inputs after a two-flop synchroniser
//   3 EDGE_STS RW1C  sticky edge status (GPIO_IRQ_EN only)
//   4 RISE_EN  RW    rising-edge enables (GPIO_IRQ_EN only)
//   5 FALL_EN  RW    falling-edge enables (GPIO_IRQ_EN only)
//   6-7        --    unmapped: read 0, writes ignored
//
// Ports
//   clk        in   system clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   wr_en_i    in   bus write enable
//   wr_addr_i  in   bus write address, bits [4:2] select the register
//   wr_data_i  in   bus write data, bits [GPIO_WIDTH-1:0] are stored
//   rd_addr_i  in   bus read address, bits [4:2] select the register
//   rd_data_o  out  registered read data, one cycle after rd_addr_i
//   gpio_i     in   asynchronous pad inputs
//   gpio_o     out  pad output values (OUT register)
//   gpio_oe_o  out  pad output enables (DIR register)
//   irq_o      out  level interrupt, OR of EDGE_STS, driven from a flop
// -----------------------------------------------------------------------------
module gpio_ctrl #(
  parameter int unsigned GPIO_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [31:0]           wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [31:0]           rd_addr_i,
  output logic [31:0]           rd_data_o,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  irq_o
);

  localparam logic [2:0] IDX_OUT      = 3'd0;
  localparam logic [2:0] IDX_DIR      = 3'd1;
  localparam logic [2:0] IDX_IN       = 3'd2;
  localparam logic [2:0] IDX_EDGE_STS = 3'd3;
  localparam logic [2:0] IDX_RISE_EN  = 3'd4;
  localparam logic [2:0] IDX_FALL_EN  = 3'd5;

  logic [2:0]            wr_idx_s;
  logic [2:0]            rd_idx_s;
  logic [GPIO_WIDTH-1:0] wr_val_s;

  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] out_d;
  logic [GPIO_WIDTH-1:0] dir_q;
  logic [GPIO_WIDTH-1:0] dir_d;
  logic [GPIO_WIDTH-1:0] sync1_q;
  logic [GPIO_WIDTH-1:0] sync2_q;
  logic [31:0]           rd_data_q;
  logic [31:0]           rd_data_d;

  // Address bits outside [4:2] and data bits above GPIO_WIDTH carry no meaning.
  logic unused_s;
  assign unused_s = ^{wr_addr_i[31:5], wr_addr_i[1:0],
                      rd_addr_i[31:5], rd_addr_i[1:0], wr_data_i};

  assign wr_idx_s = wr_addr_i[4:2];
  assign rd_idx_s = rd_addr_i[4:2];
  assign wr_val_s = wr_data_i[GPIO_WIDTH-1:0];

  // Next-state for the pad-facing OUT and DIR registers.
  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr_en_i) begin
      case (wr_idx_s)
        IDX_OUT: out_d = wr_val_s;
        IDX_DIR: dir_d = wr_val_s;
        default: begin
          out_d = out_q;
          dir_d = dir_q;
        end
      endcase
    end else begin
      out_d = out_q;
      dir_d = dir_q;
    end
  end

  // OUT and DIR storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= {GPIO_WIDTH{1'b0}};
      dir_q <= {GPIO_WIDTH{1'b0}};
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  // Two-flop synchroniser for the asynchronous pad inputs; sync2 is IN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= {GPIO_WIDTH{1'b0}};
      sync2_q <= {GPIO_WIDTH{1'b0}};
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] rise_en_q;
  logic [GPIO_WIDTH-1:0] rise_en_d;
  logic [GPIO_WIDTH-1:0] fall_en_q;
  logic [GPIO_WIDTH-1:0] fall_en_d;
  logic [GPIO_WIDTH-1:0] edge_sts_q;
  logic [GPIO_WIDTH-1:0] edge_sts_d;
  logic [GPIO_WIDTH-1:0] w1c_s;
  logic [GPIO_WIDTH-1:0] rise_s;
  logic [GPIO_WIDTH-1:0] fall_s;
  logic [GPIO_WIDTH-1:0] hit_s;
  logic                  irq_q;
  logic                  irq_d;

  // Edges are taken on the synchronised value, independent of DIR, so
  // driven pins looped back onto gpio_i still report.
  assign rise_s = sync2_q & ~prev_q;
  assign fall_s = ~sync2_q & prev_q;
  assign hit_s  = (rise_s & rise_en_q) | (fall_s & fall_en_q);

  // Next-state for the enables and the write-1-to-clear mask.
  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_s     = {GPIO_WIDTH{1'b0}};
    if (wr_en_i) begin
      case (wr_idx_s)
        IDX_EDGE_STS: w1c_s     = wr_val_s;
        IDX_RISE_EN:  rise_en_d = wr_val_s;
        IDX_FALL_EN:  fall_en_d = wr_val_s;
        default: begin
          rise_en_d = rise_en_q;
          fall_en_d = fall_en_q;
          w1c_s     = {GPIO_WIDTH{1'b0}};
        end
      endcase
    end else begin
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c_s     = {GPIO_WIDTH{1'b0}};
    end
  end

  // Status next-state: the clear is applied first so a simultaneous detect
  // wins. The interrupt flop follows the status next-state, so irq_o always
  // matches the OR of EDGE_STS without any bus-to-pin combinational path.
  always_comb begin
    edge_sts_d = (edge_sts_q & ~w1c_s) | hit_s;
    irq_d      = |edge_sts_d;
  end

  // Edge-detect history, enables, status and interrupt storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= {GPIO_WIDTH{1'b0}};
      rise_en_q  <= {GPIO_WIDTH{1'b0}};
      fall_en_q  <= {GPIO_WIDTH{1'b0}};
      edge_sts_q <= {GPIO_WIDTH{1'b0}};
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= sync2_q;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      edge_sts_q <= edge_sts_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux over the current register state; a same-cycle write is not yet
  // visible, so a colliding read returns the pre-write value.
  always_comb begin
    rd_data_d = 32'd0;
    case (rd_idx_s)
      IDX_OUT: rd_data_d[GPIO_WIDTH-1:0] = out_q;
      IDX_DIR: rd_data_d[GPIO_WIDTH-1:0] = dir_q;
      IDX_IN:  rd_data_d[GPIO_WIDTH-1:0] = sync2_q;
`ifdef GPIO_IRQ_EN
      IDX_EDGE_STS: rd_data_d[GPIO_WIDTH-1:0] = edge_sts_q;
      IDX_RISE_EN:  rd_data_d[GPIO_WIDTH-1:0] = rise_en_q;
      IDX_FALL_EN:  rd_data_d[GPIO_WIDTH-1:0] = fall_en_q;
`endif
      default: rd_data_d = 32'd0;
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 32'd0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign gpio_o    = out_q;
  assign gpio_oe_o = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_ctrl -- self-checking bench for gpio_ctrl (GPIO_WIDTH = 16).
// The reference model keeps the register contents as plain variables and the
// pad history as a short queue: IN is the pad value sampled two edges ago and
// an edge is a change between the two most recent values seen in IN.
// -----------------------------------------------------------------------------
module tb_gpio_ctrl;

  localparam int W = 16;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          wr_en_i;
  logic [31:0]   wr_addr_i;
  logic [31:0]   wr_data_i;
  logic [31:0]   rd_addr_i;
  logic [31:0]   rd_data_o;
  logic [W-1:0]  gpio_i;
  logic [W-1:0]  gpio_o;
  logic [W-1:0]  gpio_oe_o;
  logic          irq_o;

  int vectors;
  int miscompares;

  // Reference model state.
  logic [W-1:0] m_out;
  logic [W-1:0] m_dir;
  logic [W-1:0] m_ren;
  logic [W-1:0] m_fen;
  logic [W-1:0] m_sts;
  logic [W-1:0] hist[$];   // pad values captured at recent edges, newest last

  gpio_ctrl #(.GPIO_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (rd_data_o),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe_o),
    .irq_o     (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_in();
    return hist[hist.size()-2];
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] idx);
    logic [31:0] r;
    r = 32'd0;
    case (idx)
      3'd0: r[W-1:0] = m_out;
      3'd1: r[W-1:0] = m_dir;
      3'd2: r[W-1:0] = model_in();
      3'd3: if (IRQ_EN) r[W-1:0] = m_sts;
      3'd4: if (IRQ_EN) r[W-1:0] = m_ren;
      3'd5: if (IRQ_EN) r[W-1:0] = m_fen;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_ren = '0; m_fen = '0; m_sts = '0;
    hist.delete();
    for (int i = 0; i < 3; i++) hist.push_back('0);
  endtask

  task automatic check_outputs(input logic [31:0] exp_rd);
    check("rd_data_o", rd_data_o, exp_rd);
    check("gpio_o", {16'h0000, gpio_o}, {16'h0000, m_out});
    check("gpio_oe_o", {16'h0000, gpio_oe_o}, {16'h0000, m_dir});
    check("irq_o", {31'd0, irq_o}, {31'd0, |m_sts});
  endtask

  // One clock cycle: drive the bus and pads, predict, clock, compare.
  task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [31:0] ra, input logic [W-1:0] g);
    logic [W-1:0] cur_in;
    logic [W-1:0] old_in;
    logic [W-1:0] wv;
    logic [W-1:0] nsts;
    logic [31:0]  exp_rd;
    wr_en_i = we; wr_addr_i = wa; wr_data_i = wd; rd_addr_i = ra; gpio_i = g;
    cur_in = hist[hist.size()-2];
    old_in = hist[hist.size()-3];
    wv     = wd[W-1:0];
    exp_rd = mread(ra[4:2]);
    nsts   = m_sts;
    if (IRQ_EN) begin
      if (we && wa[4:2] == 3'd3) nsts = nsts & ~wv;
      nsts = nsts | (cur_in & ~old_in & m_ren) | (~cur_in & old_in & m_fen);
    end
    if (we) begin
      case (wa[4:2])
        3'd0: m_out = wv;
        3'd1: m_dir = wv;
        3'd4: if (IRQ_EN) m_ren = wv;
        3'd5: if (IRQ_EN) m_fen = wv;
        default: ;
      endcase
    end
    m_sts = nsts;
    hist.push_back(g);
    if (hist.size() > 3) void'(hist.pop_front());
    @(posedge clk);
    #1;
    check_outputs(exp_rd);
  endtask

  // Reset asserted between edges: outputs must clear immediately.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst rd_data_o", rd_data_o, 32'd0);
    check("rst gpio_o", {16'h0000, gpio_o}, 32'd0);
    check("rst gpio_oe_o", {16'h0000, gpio_oe_o}, 32'd0);
    check("rst irq_o", {31'd0, irq_o}, 32'd0);
    wr_en_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] r32;
  logic [W-1:0] pads;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; wr_en_i = 1'b0; wr_addr_i = 32'd0; wr_data_i = 32'd0;
    rd_addr_i = 32'd0; gpio_i = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("reset rd_data_o", rd_data_o, 32'd0);
    check("reset gpio_o", {16'h0000, gpio_o}, 32'd0);
    check("reset gpio_oe_o", {16'h0000, gpio_oe_o}, 32'd0);
    check("reset irq_o", {31'd0, irq_o}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // OUT/DIR write and read-back; first read collides with the OUT write.
    step(1'b1, 32'h0000_0000, 32'h0000_00A5, 32'h0000_0000, 16'h0000);
    step(1'b1, 32'h0000_0004, 32'h0000_00FF, 32'h0000_0000, 16'h0000);
    check("OUT readback", rd_data_o, 32'h0000_00A5);
    step(1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 16'h0000);
    check("DIR readback", rd_data_o, 32'h0000_00FF);

    // Input synchroniser latency on IN.
    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h0, 32'h0, 32'h0000_0008, 16'h0003);
    check("IN settled", rd_data_o, 32'h0000_0003);

    // Writes to IN and to an unmapped index are ignored.
    step(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0000_0008, 16'h0003);
    step(1'b1, 32'h0000_001C, 32'hFFFF_FFFF, 32'h0000_0008, 16'h0003);
    step(1'b0, 32'h0, 32'h0, 32'h0000_001C, 16'h0003);
    check("unmapped read", rd_data_o, 32'd0);

    // Rising edge on pin0 sets status; W1C clears it.
    step(1'b1, 32'h0000_0010, 32'h0000_0001, 32'h0000_000C, 16'h0002);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0002);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0003);
    step(1'b1, 32'h0000_000C, 32'h0000_0001, 32'h0000_000C, 16'h0003);
    step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0003);

    // Falling edge on pin1 detected in the same cycle as its W1C.
    step(1'b1, 32'h0000_0014, 32'h0000_0002, 32'h0000_000C, 16'h0001);
    step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0001);
    step(1'b1, 32'h0000_000C, 32'h0000_0002, 32'h0000_000C, 16'h0001);
    step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0001);
    step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'h0001);

    // Reset in the middle of a read of OUT=0x1234, pins high at release.
    step(1'b1, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 16'hFFFF);
    step(1'b0, 32'h0, 32'h0, 32'h0000_0000, 16'hFFFF);
    mid_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 32'h0000_000C, 16'hFFFF);

    // Randomised traffic against the model.
    pads = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r32 = $urandom;
        pads = r32[W-1:0];
      end
      if (i == 200) mid_reset();
      step(($urandom_range(0, 1) == 1), $urandom, $urandom, $urandom, pads);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 16: number of GPIO pins, legal range 1..32.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port wr_en_i  input  1  bus write enable (rib slave 3).
REQ-005 SHALL have port wr_addr_i  input  32  bus write address; bits [4:2] select register, other bits ignored.
REQ-006 SHALL have port wr_data_i  input  32  bus write data.
REQ-007 SHALL have port rd_addr_i  input  32  bus read address; bits [4:2] select register, other bits ignored.
REQ-008 SHALL have port rd_data_o  output  32  bus read data, registered.
REQ-009 SHALL have port gpio_i  input  GPIO_WIDTH  asynchronous pad inputs.
REQ-010 SHALL have port gpio_o  output  GPIO_WIDTH  pad output values (= OUT register).
REQ-011 SHALL have port gpio_oe_o  output  GPIO_WIDTH  pad output enables (= DIR register, 1 = drive).
REQ-012 SHALL have port irq_o  output  1  level interrupt request.

Function
REQ-013 SHALL map registers by word index: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 EDGE_STS (RW1C), 4 RISE_EN (RW), 5 FALL_EN (RW); indices 6-7 unmapped.
REQ-014 SHALL apply writes on the rising edge where wr_en_i=1; only bits [GPIO_WIDTH-1:0] stored; writes to IN and unmapped indices ignored.
REQ-015 SHALL register read data: rd_data_o in cycle N+1 reflects register state at end of cycle N for rd_addr_i in cycle N (one-cycle latency, matches rib registered read mux).
REQ-016 SHALL return zero in unused upper bits and for unmapped indices.
REQ-017 SHALL, for read and write to same register in same cycle, return the pre-write value.
REQ-018 SHALL synchronize gpio_i through two flops (sync1, sync2); IN reads sync2; an input change is visible in IN after 2 clock edges.
REQ-019 SHALL keep a third flop prev = previous sync2; rising edge = sync2 & ~prev, falling edge = ~sync2 & prev.
REQ-020 SHALL set EDGE_STS[i] when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); bit stays set until cleared.
REQ-021 SHALL clear EDGE_STS[i] on write of 1 to bit i of index 3; writing 0 has no effect.
REQ-022 SHALL give set priority over clear when detect and W1C hit the same bit in the same cycle.
REQ-023 SHALL drive irq_o = OR of EDGE_STS, registered from the status flops (no combinational path from bus).
REQ-024 SHALL detect edges regardless of DIR (output pins looped back on gpio_i still report).

Reset
REQ-025 SHALL, on rst=1 asynchronously, clear OUT, DIR, EDGE_STS, RISE_EN, FALL_EN, sync1, sync2, prev, rd_data_o, irq_o to 0.
REQ-026 SHALL, after rst deasserts, not report an edge for pins already high at reset release until prev has captured sync2 (pin high at release -> no rising-edge status, since enables are 0 and prev tracks sync2).
REQ-027 SHALL abort an in-flight read on reset mid-operation: rd_data_o = 0 the cycle after.

Configuration
REQ-028 SHALL honour macro GPIO_IRQ_EN: defined -> EDGE_STS, RISE_EN, FALL_EN, prev flop and irq_o logic present as above.
REQ-029 SHALL, without GPIO_IRQ_EN, omit edge logic: indices 3-5 read 0, writes ignored, irq_o tied 0; OUT/DIR/IN unchanged.

Verification
REQ-030 SHALL pass: write OUT=0x00A5, DIR=0x00FF -> gpio_o=0x00A5, gpio_oe_o=0x00FF next cycle; read index 0 -> 0x000000A5 one cycle after address.
REQ-031 SHALL pass: gpio_i 0x0000->0x0003 -> IN reads 0x0003 no earlier than 2 edges after change, 0x0000 before.
REQ-032 SHALL pass (GPIO_IRQ_EN): RISE_EN=0x0001, pin0 0->1 -> EDGE_STS=0x0001, irq_o=1; W1C 0x0001 -> EDGE_STS=0, irq_o=0.
REQ-033 SHALL pass (GPIO_IRQ_EN): FALL_EN=0x0002, pin1 falls in same cycle as W1C 0x0002 -> EDGE_STS bit1 remains 1.
REQ-034 SHALL pass: write wr_data_i=0xFFFFFFFF to index 2 and index 7 -> reads return sync2 value and 0 respectively.
REQ-035 SHALL pass: assert rst mid-sequence with OUT=0x1234 -> gpio_o=0, rd_data_o=0 immediately, no irq after release.
